// File: rtl/temp_monitor.sv
// Temperature statistics and display block: current/min/max/moving average, stale watchdog, C/F display.
// Optional over-temperature hysteresis FSM enabled by defining TEMP_ALARM_EN.
module temp_monitor #(
  parameter int DATA_W      = 8,
  parameter int AVG_LOG2    = 3,
  parameter int TIMEOUT_CYC = 200000,
  parameter int ALARM_HI    = 30,
  parameter int ALARM_HYST  = 2
) (
  input  logic              clk_200kHz,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  input  logic              clr_minmax,
  input  logic [1:0]        mode,
  input  logic              fahr,
  output logic [DATA_W-1:0] led,
  output logic              avg_valid,
  output logic              stale,
  output logic              alarm
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = DATA_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int FW     = DATA_W + 4;

  logic [DATA_W-1:0] cur, min_v, max_v;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] buf_mem [DEPTH];
  logic [AVG_LOG2-1:0] wp;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  idle_cnt;
  logic              first;
  logic              full;
  logic [DATA_W-1:0] oldest, avg, sel;

  function automatic logic [DATA_W-1:0] to_fahr(input logic [DATA_W-1:0] c);
    logic [FW-1:0] f;
    f = (FW'(c) * FW'(9)) / FW'(5) + FW'(32);
    if (f > FW'({DATA_W{1'b1}}))
      return {DATA_W{1'b1}};
    return f[DATA_W-1:0];
  endfunction

  assign full      = (fill == FILL_W'(DEPTH));
  assign avg_valid = full;
  assign oldest    = full ? buf_mem[wp] : '0;
  assign avg       = DATA_W'(sum >> AVG_LOG2);
  assign stale     = (idle_cnt == CNT_W'(TIMEOUT_CYC));

  // Window storage is data only; the fill count masks stale entries after reset.
  always_ff @(posedge clk_200kHz)
    if (sample_valid) buf_mem[wp] <= sample_data;

  always_ff @(posedge clk_200kHz or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= '0;
      min_v    <= '1;
      max_v    <= '0;
      sum      <= '0;
      wp       <= '0;
      fill     <= '0;
      idle_cnt <= '0;
      first    <= 1'b1;
    end else begin
      if (sample_valid) begin
        cur <= sample_data;
        sum <= sum + SUM_W'(sample_data) - SUM_W'(oldest);
        wp  <= wp + 1'b1;
        if (!full) fill <= fill + 1'b1;
        idle_cnt <= '0;
        if (first || clr_minmax) begin
          min_v <= sample_data;
          max_v <= sample_data;
          first <= 1'b0;
        end else begin
          if (sample_data < min_v) min_v <= sample_data;
          if (sample_data > max_v) max_v <= sample_data;
        end
      end else begin
        if (!stale) idle_cnt <= idle_cnt + 1'b1;
        if (clr_minmax) begin
          min_v <= '1;
          max_v <= '0;
          first <= 1'b1;
        end
      end
    end
  end

  // Min/max show 0 until a sample arrives, hiding the reset sentinel.
  always_comb begin
    sel = '0;
    unique case (mode)
      2'd0: sel = cur;
      2'd1: sel = first ? '0 : min_v;
      2'd2: sel = first ? '0 : max_v;
      2'd3: sel = avg_valid ? avg : '0;
      default: sel = '0;
    endcase
  end

  always_ff @(posedge clk_200kHz or negedge rst_n) begin
    if (!rst_n) led <= '0;
    else        led <= fahr ? to_fahr(sel) : sel;
  end

`ifdef TEMP_ALARM_EN
  typedef enum logic {ST_NORMAL, ST_ALARM} state_t;
  state_t state;

  always_ff @(posedge clk_200kHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_NORMAL;
      alarm <= 1'b0;
    end else if (stale) begin
      state <= ST_NORMAL;
      alarm <= 1'b0;
    end else if (sample_valid) begin
      unique case (state)
        ST_NORMAL:
          if (sample_data >= DATA_W'(ALARM_HI)) begin
            state <= ST_ALARM;
            alarm <= 1'b1;
          end
        ST_ALARM:
          if (sample_data <= DATA_W'(ALARM_HI - ALARM_HYST)) begin
            state <= ST_NORMAL;
            alarm <= 1'b0;
          end
        default: begin
          state <= ST_NORMAL;
          alarm <= 1'b0;
        end
      endcase
    end
  end
`else
  localparam int unused_alarm_cfg = ALARM_HI + ALARM_HYST;
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_temp_monitor.sv
// Directed bench for temp_monitor with hand-computed expectations (AVG_LOG2=3, TIMEOUT_CYC=100).
module tb_temp_monitor;

  logic       clk_200kHz = 1'b0;
  logic       rst_n;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       clr_minmax;
  logic [1:0] mode;
  logic       fahr;
  logic [7:0] led;
  logic       avg_valid;
  logic       stale;
  logic       alarm;

  int vectors = 0;
  int miscompares = 0;

  temp_monitor #(
    .DATA_W(8), .AVG_LOG2(3), .TIMEOUT_CYC(100), .ALARM_HI(30), .ALARM_HYST(2)
  ) dut (
    .clk_200kHz(clk_200kHz), .rst_n(rst_n), .sample_data(sample_data),
    .sample_valid(sample_valid), .clr_minmax(clr_minmax), .mode(mode), .fahr(fahr),
    .led(led), .avg_valid(avg_valid), .stale(stale), .alarm(alarm)
  );

  always #5 clk_200kHz = ~clk_200kHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_200kHz);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input logic clr);
    sample_data  = v;
    sample_valid = 1'b1;
    clr_minmax   = clr;
    tick(1);
    sample_valid = 1'b0;
    clr_minmax   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n = 1'b1; sample_data = '0; sample_valid = 1'b0; clr_minmax = 1'b0;
    mode = 2'd0; fahr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_led", led, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_stale", stale, 0);
    check("rst_alarm", alarm, 0);
    @(posedge clk_200kHz); #1;
    rst_n = 1'b1;

    // Min/max/avg before any sample display 0
    mode = 2'd1; tick(1); check("min_before_sample", led, 0);
    mode = 2'd2; tick(1); check("max_before_sample", led, 0);
    mode = 2'd3; tick(1); check("avg_before_fill", led, 0);

    // Current/min/max with 2-cycle sample latency
    mode = 2'd0;
    send(8'd20, 1'b0); send(8'd22, 1'b0); send(8'd24, 1'b0);
    check("cur_latency_prev", led, 22);
    tick(1); check("cur_24", led, 24);
    mode = 2'd1; tick(1); check("min_20", led, 20);
    mode = 2'd2; tick(1); check("max_24", led, 24);
    check("avg_valid_partial", avg_valid, 0);

    // Moving average over 8 samples
    do_reset();
    for (int i = 0; i < 7; i++) send(8'(10 + i), 1'b0);
    check("avg_valid_7", avg_valid, 0);
    send(8'd17, 1'b0);
    check("avg_valid_8", avg_valid, 1);
    mode = 2'd3; tick(1); check("avg_10_17", led, 13);
    send(8'd26, 1'b0); tick(1); check("avg_after_26", led, 15);
    mode = 2'd1; tick(1); check("min_window", led, 10);
    mode = 2'd2; tick(1); check("max_window", led, 26);

    // Fahrenheit conversion and toggle latency
    do_reset();
    mode = 2'd0;
    send(8'd25, 1'b0);
    fahr = 1'b1; tick(1); check("fahr_25", led, 77);
    fahr = 1'b0; tick(1); check("fahr_off_25", led, 25);
    fahr = 1'b1;
    send(8'd0, 1'b0);   tick(1); check("fahr_0", led, 32);
    send(8'd255, 1'b0); tick(1); check("fahr_sat_255", led, 255);
    send(8'd100, 1'b0); tick(1); check("fahr_100", led, 212);
    fahr = 1'b0;

    // clr_minmax with and without a coincident sample
    do_reset();
    send(8'd15, 1'b0); send(8'd30, 1'b0);
    mode = 2'd1; tick(1); check("min_15", led, 15);
    send(8'd18, 1'b1);
    tick(1); check("clr_min_18", led, 18);
    mode = 2'd2; tick(1); check("clr_max_18", led, 18);
    send(8'd21, 1'b0); tick(1); check("max_after_clr", led, 21);
    clr_minmax = 1'b1; tick(1); clr_minmax = 1'b0;
    tick(1); check("max_cleared_shows0", led, 0);
    mode = 2'd1; tick(1); check("min_cleared_shows0", led, 0);

    // Stale watchdog
    do_reset();
    mode = 2'd0;
    send(8'd5, 1'b0);
    tick(99); check("stale_99", stale, 0);
    tick(1);  check("stale_100", stale, 1);
    tick(5);  check("stale_hold", stale, 1);
    check("stats_kept_stale", led, 5);
    send(8'd6, 1'b0); check("stale_cleared", stale, 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 8; i++) send(8'd40, 1'b0);
    check("avg_valid_before_rst", avg_valid, 1);
    mode = 2'd3; tick(1); check("avg_40", led, 40);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", led, 0);
    check("async_rst_avg_valid", avg_valid, 0);
    check("async_rst_stale", stale, 0);
    check("async_rst_alarm", alarm, 0);
    rst_n = 1'b1;
    tick(1);
    send(8'd50, 1'b0);
    mode = 2'd1; tick(1); check("first_after_rst_min", led, 50);
    mode = 2'd3; tick(1); check("avg_after_rst", led, 0);

    // Over-temperature flag
    do_reset();
`ifdef TEMP_ALARM_EN
    send(8'd29, 1'b0); check("alarm_29", alarm, 0);
    send(8'd30, 1'b0); check("alarm_30", alarm, 1);
    send(8'd29, 1'b0); check("alarm_hold_29", alarm, 1);
    send(8'd27, 1'b0); check("alarm_clear_27", alarm, 0);
    send(8'd31, 1'b0); check("alarm_31", alarm, 1);
    send(8'd28, 1'b0); check("alarm_clear_28", alarm, 0);
`else
    send(8'd30, 1'b0); check("alarm_off_30", alarm, 0);
    send(8'd45, 1'b0); check("alarm_off_45", alarm, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
